// File: rtl/port_arbiter.sv
// Three-requester packet arbiter: round-robin grant held for a whole packet, combinational data path.
// Optional watchdog (ARB_WATCHDOG_EN) abandons a stalled lock and raises sticky o_timeout.
module port_arbiter #(
  parameter int DataWidth     = 36,
  parameter int TimeoutCycles = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [3*DataWidth-1:0] i_req_data,
  input  logic [2:0]             i_req_valid,
  input  logic [2:0]             i_req_last,
  output logic [2:0]             o_req_ready,
  output logic [DataWidth-1:0]   o_data,
  output logic                   o_data_valid,
  input  logic                   i_data_ready,
  output logic [2:0]             o_grant
`ifdef ARB_WATCHDOG_EN
  ,
  output logic                   o_timeout
`endif
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic   [1:0]         r_last;
  logic   [1:0]         w_last_nxt;
  logic   [2:0]         w_gnt_oh;
  logic   [2:0]         w_arb;
  logic                 w_locked;
  logic                 w_gvalid;
  logic                 w_glast;
  logic                 w_xfer;
  logic                 w_wd_hit;
  logic [DataWidth-1:0] w_sel;

  // Round-robin pick: scan last+1, last+2, last (mod 3).
  function automatic logic [2:0] f_arb(input logic [2:0] v, input logic [1:0] last);
    logic [2:0] g;
    case (last)
      2'd0:    g = v[1] ? 3'b010 : v[2] ? 3'b100 : v[0] ? 3'b001 : 3'b000;
      2'd1:    g = v[2] ? 3'b100 : v[0] ? 3'b001 : v[1] ? 3'b010 : 3'b000;
      default: g = v[0] ? 3'b001 : v[1] ? 3'b010 : v[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] f_idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign w_locked = (r_state == ST_LOCKED);
  assign w_gnt_oh = w_locked ? f_onehot(r_last) : 3'b000;
  assign w_gvalid = |(i_req_valid & w_gnt_oh);
  assign w_glast  = |(i_req_last & w_gnt_oh);
  assign w_xfer   = w_gvalid & i_data_ready;
  assign w_arb    = f_arb(i_req_valid, r_last);

  always_comb begin
    case (r_last)
      2'd0:    w_sel = i_req_data[0*DataWidth +: DataWidth];
      2'd1:    w_sel = i_req_data[1*DataWidth +: DataWidth];
      default: w_sel = i_req_data[2*DataWidth +: DataWidth];
    endcase
  end

  assign o_grant      = w_gnt_oh;
  assign o_data       = w_locked ? w_sel : '0;
  assign o_data_valid = w_gvalid;
  assign o_req_ready  = w_gnt_oh & {3{i_data_ready}};

`ifdef ARB_WATCHDOG_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TimeoutCycles);

  logic [7:0] r_wd_cnt;
  logic       r_timeout;

  assign w_wd_hit  = w_locked && !w_gvalid && ((r_wd_cnt + 8'd1) >= LP_TIMEOUT);
  assign o_timeout = r_timeout;

  // Counter restarts on every new lock and every accepted flit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wd_cnt  <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if ((!w_locked && w_state_nxt == ST_LOCKED) || w_xfer) begin
        r_wd_cnt <= 8'd0;
      end else if (w_locked && !w_gvalid) begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end
      if (w_wd_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    if (!w_locked) begin
      if (|i_req_valid) begin
        w_state_nxt = ST_LOCKED;
        w_last_nxt  = f_idx(w_arb);
      end
    end else if (w_xfer && w_glast) begin
      // Tail accepted: re-arbitrate from the current grant, including itself.
      if (|w_arb) begin
        w_last_nxt = f_idx(w_arb);
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_wd_hit) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: reset, round-robin, packet lock, backpressure, reset abort, lone requester, watchdog.
module tb_port_arbiter;

  localparam int DW = 36;

  logic            clk;
  logic            rst;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_valid;
  logic [2:0]      req_last;
  logic [2:0]      req_ready;
  logic [DW-1:0]   data;
  logic            data_valid;
  logic            data_ready;
  logic [2:0]      grant;
`ifdef ARB_WATCHDOG_EN
  logic            timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  port_arbiter #(.DataWidth(DW), .TimeoutCycles(16)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_data   (req_data),
    .i_req_valid  (req_valid),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_data       (data),
    .o_data_valid (data_valid),
    .i_data_ready (data_ready),
    .o_grant      (grant)
`ifdef ARB_WATCHDOG_EN
    ,
    .o_timeout    (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] flit(input int r, input int k);
    logic [DW-1:0] f;
    f = {4'(r + 1), 32'(k) ^ 32'hA5A5_0000};
    return f;
  endfunction

  task automatic set_flits(input int k);
    for (int r = 0; r < 3; r++) req_data[r*DW +: DW] = flit(r, k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 3'b000;
    req_last   = 3'b000;
    data_ready = 1'b0;
    set_flits(0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant got=%b exp=000", grant); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data); end
`ifdef ARB_WATCHDOG_EN
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
`endif
    data_ready = 1'b1;
    tick();
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL idle_grant got=%b exp=000", grant); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int         exp_r [4] = '{0, 1, 2, 0};
    do_reset();
    data_ready = 1'b1;
    req_valid  = 3'b111;
    req_last   = 3'b111;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_flits(i + 1);
      #1;
      n_checks++; if (grant !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, exp_g[i]); end
      n_checks++; if (data !== flit(exp_r[i], i + 1)) begin n_fail++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, data, flit(exp_r[i], i + 1)); end
      n_checks++; if (req_ready !== exp_g[i]) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_g[i]); end
      tick();
    end
  endtask

  task automatic test_long_packet();
    do_reset();
    data_ready = 1'b1;
    req_valid  = 3'b010;
    tick();
    req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      set_flits(10 + i);
      req_last = (i == 3) ? 3'b011 : 3'b001;
      #1;
      n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL pkt_grant[%0d] got=%b exp=010", i, grant); end
      n_checks++; if (data !== flit(1, 10 + i) || data_valid !== 1'b1) begin n_fail++; $display("FAIL pkt_data[%0d] got=%h/%b exp=%h/1", i, data, data_valid, flit(1, 10 + i)); end
      tick();
    end
    n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL pkt_switch got=%b exp=001", grant); end
  endtask

  task automatic test_backpressure();
    do_reset();
    data_ready = 1'b1;
    req_valid  = 3'b001;
    tick();
    set_flits(20);
    #1;
    n_checks++; if (data !== flit(0, 20) || req_ready !== 3'b001) begin n_fail++; $display("FAIL bp_first got=%h/%b exp=%h/001", data, req_ready, flit(0, 20)); end
    tick();
    set_flits(21);
    req_valid  = 3'b011;
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (data !== flit(0, 21)) begin n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, data, flit(0, 21)); end
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=000", i, req_ready); end
      n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL bp_grant[%0d] got=%b exp=001", i, grant); end
      tick();
    end
    data_ready = 1'b1;
    #1;
    n_checks++; if (data !== flit(0, 21) || req_ready !== 3'b001) begin n_fail++; $display("FAIL bp_release got=%h/%b exp=%h/001", data, req_ready, flit(0, 21)); end
    tick();
    set_flits(22);
    req_last = 3'b001;
    #1;
    n_checks++; if (data !== flit(0, 22) || grant !== 3'b001) begin n_fail++; $display("FAIL bp_next got=%h/%b exp=%h/001", data, grant, flit(0, 22)); end
    tick();
    n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL bp_after got=%b exp=010", grant); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    data_ready = 1'b1;
    req_valid  = 3'b111;
    req_last   = 3'b001;
    tick();
    tick();
    req_last = 3'b000;
    #1;
    n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rmid_pre got=%b exp=010", grant); end
    rst = 1'b1;
    tick();
    n_checks++; if (grant !== 3'b000 || data_valid !== 1'b0 || req_ready !== 3'b000) begin n_fail++; $display("FAIL rmid_abort got=%b/%b/%b exp=000/0/000", grant, data_valid, req_ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL rmid_regrant got=%b exp=001", grant); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_ready = 1'b1;
    req_valid  = 3'b100;
    req_last   = 3'b100;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_flits(30 + i);
      #1;
      n_checks++; if (grant !== 3'b100 || req_ready !== 3'b100) begin n_fail++; $display("FAIL b2b_grant[%0d] got=%b/%b exp=100/100", i, grant, req_ready); end
      n_checks++; if (data !== flit(2, 30 + i) || data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, data, flit(2, 30 + i)); end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    data_ready = 1'b1;
    req_valid  = 3'b001;
    tick();
    tick();
    req_valid = 3'b000;
`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (grant !== 3'b001 || timeout !== 1'b0) begin n_fail++; $display("FAIL wd_before got=%b/%b exp=001/0", grant, timeout); end
    tick();
    n_checks++; if (grant !== 3'b000 || timeout !== 1'b1) begin n_fail++; $display("FAIL wd_fire got=%b/%b exp=000/1", grant, timeout); end
    req_valid = 3'b010;
    tick();
    n_checks++; if (grant !== 3'b010 || timeout !== 1'b1) begin n_fail++; $display("FAIL wd_next got=%b/%b exp=010/1", grant, timeout); end
`else
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (grant !== 3'b001 || data_valid !== 1'b0) begin n_fail++; $display("FAIL hold_grant got=%b/%b exp=001/0", grant, data_valid); end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 3'b000;
    req_last   = 3'b000;
    data_ready = 1'b0;
    req_data   = '0;
    test_reset();
    test_round_robin();
    test_long_packet();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    test_stall_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
